mult_share_ctrl: RTL
====================

Name: mult_share_ctrl

Overview:
- Controller and arbiter that shares one iterative 8-bit multiplier among NREQ requesters.
- Per-requester valid/ready request handshake; round-robin grant.
- Sequences the multiplier through a START/DONE interface, with a bypass for zero operands and a watchdog timeout.
- Returns a tagged result on a single response channel. Sits between client blocks and the shared multiplier datapath.

Parameters:
- NREQ, 4, number of requesters (2..8)
- WIDTH, 8, operand and product width
- TIMEOUT, 64, max WAIT cycles before abort (≥1)
- IDW, 2, requester ID width, equals clog2(NREQ)

Ports:
- CLK  in  1  rising-edge clock
- RESET  in  1  asynchronous, active-low reset
- REQ_VALID  in  NREQ  request pending, one bit per requester
- REQ_A  in  NREQ*WIDTH  packed operand A; slice i belongs to requester i
- REQ_B  in  NREQ*WIDTH  packed operand B
- REQ_READY  out  NREQ  one-hot accept; transfer when REQ_VALID[i] & REQ_READY[i]
- RSP_VALID  out  1  response valid
- RSP_ID  out  IDW  requester that owns the response
- RSP_DATA  out  WIDTH  product, truncated to WIDTH
- RSP_ERR  out  1  timeout abort; RSP_DATA=0 when set
- RSP_READY  in  1  consumer accepts response
- MUL_START  out  1  one-cycle start pulse to the multiplier
- MUL_A  out  WIDTH  multiplicand, stable from START until DONE or abort
- MUL_B  out  WIDTH  multiplier operand, stable likewise
- MUL_DONE  in  1  multiplier finished; MUL_P valid this cycle
- MUL_P  in  WIDTH  multiplier product

Behaviour:
- Reset (RESET=0, async): state=IDLE, rr pointer=0, wait counter=0.
- Reset values of outputs: REQ_READY=0, RSP_VALID=0, RSP_ID=0, RSP_DATA=0, RSP_ERR=0, MUL_START=0, MUL_A=0, MUL_B=0.
- Reset mid-operation: any transaction in flight is dropped with no response. The multiplier is not notified; MUL_DONE arriving after reset is ignored.
- Grant rule: first requester with REQ_VALID=1 searching upward from the rr pointer, wrapping mod NREQ.
- IDLE:
  - If any REQ_VALID, REQ_READY[g]=1 combinationally for the granted g only, in that same cycle.
  - On the transfer edge, latch A, B and ID=g.
  - If A==0 or B==0: go to RESP with data=0, no MUL_START.
  - Otherwise: go to ISSUE.
- ISSUE: MUL_START=1 for exactly one cycle; MUL_A/MUL_B driven from the latches; counter cleared; go to WAIT.
- WAIT:
  - Counter increments each cycle.
  - On MUL_DONE=1: latch MUL_P, RSP_ERR=0, go to RESP.
  - If the counter reaches TIMEOUT with no DONE: RSP_ERR=1, data=0, go to RESP.
  - DONE and the timeout in the same cycle: DONE wins.
- RESP:
  - RSP_VALID=1 with RSP_ID/RSP_DATA/RSP_ERR held stable until RSP_READY=1.
  - On the handshake: RSP_VALID drops next cycle, rr pointer becomes (ID+1) mod NREQ, go to IDLE.
  - No new grant is issued in the handshake cycle.
- REQ_READY is 0 in every state except IDLE.
- MUL_DONE outside WAIT is ignored.
- A requester may drop REQ_VALID before it is granted without error.
- Latency:
  - Zero-operand request accepted at cycle T: RSP_VALID at T+1.
  - Normal request: MUL_START at T+1, RSP_VALID the cycle after MUL_DONE.
- Back-to-back throughput: one transaction in flight, minimum 2 cycles per transaction (zero bypass).
- Arithmetic: result is the lower WIDTH bits of the product, with no overflow flag.

Decomposition:
- Shared package mult_share_pkg holds:
  - state encoding: IDLE=2'b00, ISSUE=2'b01, WAIT=2'b10, RESP=2'b11
  - default WIDTH/NREQ/TIMEOUT constants
  - the IDW computation
- One sub-module, mult_rr_arbiter, combinational: NREQ request vector plus rr pointer in, one-hot grant plus encoded ID and any-valid out.
- The FSM, latches, counter and pointer stay in mult_share_ctrl.

Test Plan:
- Single request: REQ_VALID=0001, A=6, B=7; multiplier model gives DONE after 6 cycles with P=42 → one MUL_START, RSP_ID=0, RSP_DATA=42, RSP_ERR=0.
- All four requesters valid at once, operands (i+1)*3 → responses in ID order 0,1,2,3. Requester 0 re-requests during ID 1's response → its grant follows ID 3.
- Zero bypass: requester 2, A=0, B=55 → no MUL_START, RSP_VALID one cycle after accept, RSP_DATA=0, RSP_ID=2.
- Truncation and backpressure: A=20, B=20, P=400 mod 256=144; RSP_READY held low 5 cycles → RSP_VALID/DATA=144 stable, no REQ_READY asserted meanwhile.
- Timeout: multiplier model never asserts DONE → RSP_ERR=1, RSP_DATA=0 exactly TIMEOUT WAIT cycles after START, then the next requester is served normally.
- Reset in WAIT: assert RESET=0 mid-WAIT → all outputs at reset values immediately. A late MUL_DONE is ignored, and the next request goes to requester 0 first.

Source files
------------

// File: rtl/mult_share_pkg.sv
// Shared types and defaults for the multiplier-sharing controller slice.
package mult_share_pkg;

  localparam int unsigned DEF_NREQ    = 4;
  localparam int unsigned DEF_WIDTH   = 8;
  localparam int unsigned DEF_TIMEOUT = 64;

  // Requester ID width; never narrower than one bit.
  function automatic int unsigned calc_idw(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  localparam int unsigned DEF_IDW = calc_idw(DEF_NREQ);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01,
    WAIT  = 2'b10,
    RESP  = 2'b11
  } state_t;

endpackage

// File: rtl/mult_rr_arbiter.sv
// Combinational round-robin arbiter: first active request at or above ptr, wrapping.
module mult_rr_arbiter
  import mult_share_pkg::*;
#(
  parameter int unsigned NREQ = DEF_NREQ,
  parameter int unsigned IDW  = calc_idw(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  gnt_id,
  output logic            any_req
);

  logic [NREQ-1:0] rot;
  int unsigned     pos;

  // Rotate requests so the pointer lands on bit 0, pick the lowest, un-rotate the index.
  always_comb begin
    rot     = NREQ'({req, req} >> ptr);
    any_req = 1'b0;
    pos     = 0;
    gnt     = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (!any_req && rot[k]) begin
        any_req = 1'b1;
        pos     = 32'(ptr) + k;
      end
    end
    if (pos >= NREQ) begin
      pos = pos - NREQ;
    end
    gnt_id = IDW'(pos);
    for (int unsigned i = 0; i < NREQ; i++) begin
      gnt[i] = any_req && (gnt_id == IDW'(i));
    end
  end

endmodule

// File: rtl/mult_share_ctrl.sv
// Shares one iterative multiplier among NREQ requesters with round-robin grant,
// zero-operand bypass, watchdog abort and a single tagged response channel.
module mult_share_ctrl
  import mult_share_pkg::*;
#(
  parameter int unsigned NREQ    = DEF_NREQ,
  parameter int unsigned WIDTH   = DEF_WIDTH,
  parameter int unsigned TIMEOUT = DEF_TIMEOUT,
  parameter int unsigned IDW     = calc_idw(NREQ)
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [NREQ-1:0]       REQ_VALID,
  input  logic [NREQ*WIDTH-1:0] REQ_A,
  input  logic [NREQ*WIDTH-1:0] REQ_B,
  output logic [NREQ-1:0]       REQ_READY,
  output logic                  RSP_VALID,
  output logic [IDW-1:0]        RSP_ID,
  output logic [WIDTH-1:0]      RSP_DATA,
  output logic                  RSP_ERR,
  input  logic                  RSP_READY,
  output logic                  MUL_START,
  output logic [WIDTH-1:0]      MUL_A,
  output logic [WIDTH-1:0]      MUL_B,
  input  logic                  MUL_DONE,
  input  logic [WIDTH-1:0]      MUL_P
);

  localparam int unsigned CNTW = $clog2(TIMEOUT + 1);

  state_t          state;
  logic [IDW-1:0]  rr_ptr;
  logic [IDW-1:0]  id_q;
  logic [CNTW-1:0] wait_cnt;

  logic [NREQ-1:0]  gnt;
  logic [IDW-1:0]   gnt_id;
  logic             any_req;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;

  mult_rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .req     (REQ_VALID),
    .ptr     (rr_ptr),
    .gnt     (gnt),
    .gnt_id  (gnt_id),
    .any_req (any_req)
  );

  // Operand mux for the granted requester.
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (gnt_id == IDW'(i)) begin
        sel_a = REQ_A[i*WIDTH +: WIDTH];
        sel_b = REQ_B[i*WIDTH +: WIDTH];
      end
    end
  end

  // Grant is only offered while idle and out of reset.
  assign REQ_READY = ((state == IDLE) && RESET) ? gnt : '0;

  // Controller FSM with registered response and multiplier-side outputs.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      id_q      <= '0;
      wait_cnt  <= '0;
      RSP_VALID <= 1'b0;
      RSP_ID    <= '0;
      RSP_DATA  <= '0;
      RSP_ERR   <= 1'b0;
      MUL_START <= 1'b0;
      MUL_A     <= '0;
      MUL_B     <= '0;
    end else begin
      MUL_START <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            id_q <= gnt_id;
            if ((sel_a == '0) || (sel_b == '0)) begin
              RSP_VALID <= 1'b1;
              RSP_ID    <= gnt_id;
              RSP_DATA  <= '0;
              RSP_ERR   <= 1'b0;
              state     <= RESP;
            end else begin
              MUL_A     <= sel_a;
              MUL_B     <= sel_b;
              MUL_START <= 1'b1;
              state     <= ISSUE;
            end
          end
        end
        ISSUE: begin
          wait_cnt <= '0;
          state    <= WAIT;
        end
        WAIT: begin
          if (MUL_DONE) begin
            RSP_VALID <= 1'b1;
            RSP_ID    <= id_q;
            RSP_DATA  <= MUL_P;
            RSP_ERR   <= 1'b0;
            state     <= RESP;
          end else if (wait_cnt == CNTW'(TIMEOUT - 1)) begin
            RSP_VALID <= 1'b1;
            RSP_ID    <= id_q;
            RSP_DATA  <= '0;
            RSP_ERR   <= 1'b1;
            state     <= RESP;
          end else begin
            wait_cnt <= wait_cnt + CNTW'(1);
          end
        end
        RESP: begin
          if (RSP_READY) begin
            RSP_VALID <= 1'b0;
            rr_ptr    <= (id_q == IDW'(NREQ - 1)) ? '0 : id_q + IDW'(1);
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
